// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: FSM state encoding,
// divider iteration count and bit positions inside the decoded control pairs.
package md_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_FIX  = 2'd3
   } md_state_t;

   localparam int DIV_ITER = 32;

   // MULT/DIV pairs: [1]=unsigned variant, [0]=signed variant
   localparam int OP_UNS = 1;
   localparam int OP_SGN = 0;

   // MFHL/MTHL pairs: [1]=HI, [0]=LO
   localparam int SEL_HI = 1;
   localparam int SEL_LO = 0;

endpackage

// File: rtl/div_radix2_core.sv
// Iterative restoring radix-2 divider: latches magnitudes and result signs on
// start, runs ITER shift/subtract steps, then presents the sign-fixed result.
module div_radix2_core
   import md_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ITER   = DIV_ITER
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start,
   input  logic              is_unsigned,
   input  logic [DATA_W-1:0] dividend,
   input  logic [DATA_W-1:0] divisor,
   output logic              last_step,
   output logic              done,
   output logic [DATA_W-1:0] quotient,
   output logic [DATA_W-1:0] remainder
);

   localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

   logic              run;
   logic              fix;
   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] rem;
   logic [DATA_W-1:0] quo;
   logic [DATA_W-1:0] dvs;
   logic              q_neg;
   logic              r_neg;

   logic              neg_a;
   logic              neg_b;
   logic [DATA_W-1:0] abs_a;
   logic [DATA_W-1:0] abs_b;
   logic [DATA_W:0]   rem_sh;
   logic [DATA_W:0]   trial;

   assign neg_a = ~is_unsigned & dividend[DATA_W-1];
   assign neg_b = ~is_unsigned & divisor[DATA_W-1];
   // The most negative value maps onto itself, which is its correct unsigned magnitude.
   assign abs_a = neg_a ? (DATA_W'(0) - dividend) : dividend;
   assign abs_b = neg_b ? (DATA_W'(0) - divisor)  : divisor;

   // Dividend bits shift out of quo's MSB while quotient bits shift in at its LSB.
   assign rem_sh = {rem, quo[DATA_W-1]};
   assign trial  = rem_sh - {1'b0, dvs};

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         run   <= 1'b0;
         fix   <= 1'b0;
         cnt   <= '0;
         rem   <= '0;
         quo   <= '0;
         dvs   <= '0;
         q_neg <= 1'b0;
         r_neg <= 1'b0;
      end else if (start) begin
         run   <= 1'b1;
         fix   <= 1'b0;
         cnt   <= CW'(ITER - 1);
         rem   <= '0;
         quo   <= abs_a;
         dvs   <= abs_b;
         q_neg <= neg_a ^ neg_b;
         r_neg <= neg_a;
      end else if (run) begin
         if (!trial[DATA_W]) begin
            rem <= trial[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b1};
         end else begin
            rem <= rem_sh[DATA_W-1:0];
            quo <= {quo[DATA_W-2:0], 1'b0};
         end
         if (cnt == '0) begin
            run <= 1'b0;
            fix <= 1'b1;
         end else begin
            cnt <= cnt - CW'(1);
         end
      end else if (fix) begin
         fix <= 1'b0;
      end
   end

   assign last_step = run & (cnt == '0);
   assign done      = fix;
   assign quotient  = q_neg ? (DATA_W'(0) - quo) : quo;
   assign remainder = r_neg ? (DATA_W'(0) - rem) : rem;

endmodule

// File: rtl/hilo_md_unit.sv
// EX-stage HI/LO responder: multi-cycle MULT(U)/DIV(U), MTHI/MTLO writes,
// MFHI/MFLO reads and the pipeline hold for HI/LO instructions while busy.
//
// state   | meaning
// IDLE    | ready; accepts MULT/DIV/MT/MF from EX
// MUL     | product counting down MUL_LAT cycles, written at terminal count
// DIV     | divider core stepping one quotient bit per cycle
// FIX     | divider sign fix; HI=remainder, LO=quotient written on exit
module hilo_md_unit
   import md_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MUL_LAT = 2
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              issue_valid,
   input  logic              flush,
   input  logic [1:0]        MULT,
   input  logic [1:0]        DIV,
   input  logic [1:0]        MFHL,
   input  logic [1:0]        MTHL,
   input  logic [DATA_W-1:0] src_a,
   input  logic [DATA_W-1:0] src_b,
   output logic              md_stall,
   output logic              busy,
   output logic [DATA_W-1:0] hilo_rdata,
   output logic [DATA_W-1:0] hi_q,
   output logic [DATA_W-1:0] lo_q
);

   localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   md_state_t           state;
   md_state_t           state_nx;

   logic [DATA_W-1:0]   hi;
   logic [DATA_W-1:0]   lo;
   logic [DATA_W-1:0]   mul_a;
   logic [DATA_W-1:0]   mul_b;
   logic                mul_sgn;
   logic [CW-1:0]       mul_cnt;
   logic [2*DATA_W-1:0] mul_ext_a;
   logic [2*DATA_W-1:0] mul_ext_b;
   logic [2*DATA_W-1:0] product;

   logic                accept;
   logic                op_div;
   logic                op_mult;
   logic                op_mt;
   logic                div_start;
   logic                div_last;
   logic                div_done;
   logic [DATA_W-1:0]   div_quo;
   logic [DATA_W-1:0]   div_rem;

   assign accept    = issue_valid & ~flush & (state == ST_IDLE);
   // Illegal multi-hot decode resolves DIV > MULT > MTHL > MFHL.
   assign op_div    = |DIV;
   assign op_mult   = ~op_div & (|MULT);
   assign op_mt     = ~op_div & ~(|MULT) & (|MTHL);
   assign div_start = accept & op_div & (src_b != '0);

   assign mul_ext_a = mul_sgn ? {{DATA_W{mul_a[DATA_W-1]}}, mul_a} : {{DATA_W{1'b0}}, mul_a};
   assign mul_ext_b = mul_sgn ? {{DATA_W{mul_b[DATA_W-1]}}, mul_b} : {{DATA_W{1'b0}}, mul_b};
   assign product   = mul_ext_a * mul_ext_b;

   div_radix2_core #(
      .DATA_W (DATA_W),
      .ITER   (DATA_W)
   ) u_div (
      .clk         (clk),
      .resetn      (resetn),
      .start       (div_start),
      .is_unsigned (~DIV[OP_SGN]),
      .dividend    (src_a),
      .divisor     (src_b),
      .last_step   (div_last),
      .done        (div_done),
      .quotient    (div_quo),
      .remainder   (div_rem)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE: begin
            if (div_start) begin
               state_nx = ST_DIV;
            end else if (accept && op_mult) begin
               state_nx = ST_MUL;
            end
         end
         ST_MUL: begin
            if (mul_cnt == '0) begin
               state_nx = ST_IDLE;
            end
         end
         ST_DIV: begin
            if (div_last) begin
               state_nx = ST_FIX;
            end
         end
         ST_FIX: begin
            if (div_done) begin
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         hi      <= '0;
         lo      <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_sgn <= 1'b0;
         mul_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept && op_mult) begin
                  mul_a   <= src_a;
                  mul_b   <= src_b;
                  mul_sgn <= MULT[OP_SGN];
                  mul_cnt <= CW'(MUL_LAT - 1);
               end else if (accept && op_mt) begin
                  if (MTHL[SEL_LO]) begin
                     lo <= src_a;
                  end else begin
                     hi <= src_a;
                  end
               end
            end
            ST_MUL: begin
               if (mul_cnt == '0) begin
                  {hi, lo} <= product;
               end else begin
                  mul_cnt <= mul_cnt - CW'(1);
               end
            end
            ST_FIX: begin
               if (div_done) begin
                  hi <= div_rem;
                  lo <= div_quo;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      busy       = (state != ST_IDLE);
      // A flushed instruction is dropped anyway, so it is never held.
      md_stall   = busy & issue_valid & ~flush & (|{MULT, DIV, MFHL, MTHL});
      hilo_rdata = (MFHL[SEL_HI] & ~MFHL[SEL_LO]) ? hi : lo;
      hi_q       = hi;
      lo_q       = lo;
   end

endmodule
